// File: rtl/pipe_pkg.sv
// Shared constants and types for the pipeline stage registers.
// Exception codes follow the MIPS CP0 Cause.ExcCode numbering.
package pipe_pkg;

    localparam int EXC_CODE_W = 5;
    localparam int NOEXC_CODE = 15;

    localparam int EXC_INT  = 0;
    localparam int EXC_ADEL = 4;
    localparam int EXC_ADES = 5;
    localparam int EXC_SYS  = 8;
    localparam int EXC_BP   = 9;
    localparam int EXC_RI   = 10;
    localparam int EXC_OV   = 12;

    typedef struct packed {
        logic                  exc;
        logic [EXC_CODE_W-1:0] exccode;
        logic [31:0]           badvaddr;
    } exc_t;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } skid_state_e;

endpackage

// File: rtl/pipe_exc_merge.sv
// First-exception-wins selection between an exception carried in from
// upstream and one detected in the current stage.
// Macro PIPE_SKID_STAGE_EXC_MERGE_EN enables the merge; without it the
// upstream exception fields pass through and new_* is ignored.
module pipe_exc_merge
    import pipe_pkg::*;
#(
    parameter int CODE_W     = 5,
    parameter int NOEXC_CODE = 15
) (
    input  logic              in_exc,
    input  logic [CODE_W-1:0] in_exccode,
    input  logic [31:0]       in_badvaddr,
    input  logic              new_exc,
    input  logic [CODE_W-1:0] new_exccode,
    input  logic [31:0]       new_badvaddr,
    output logic              out_exc,
    output logic [CODE_W-1:0] out_exccode,
    output logic [31:0]       out_badvaddr
);

    localparam logic [CODE_W-1:0] NOEXC = CODE_W'(NOEXC_CODE);

`ifdef PIPE_SKID_STAGE_EXC_MERGE_EN
    // An older (upstream) exception always takes precedence over a local one.
    always_comb begin
        out_exc      = 1'b0;
        out_exccode  = NOEXC;
        out_badvaddr = in_badvaddr;
        if (in_exc) begin
            out_exc      = 1'b1;
            out_exccode  = in_exccode;
            out_badvaddr = in_badvaddr;
        end else if (new_exc) begin
            out_exc      = 1'b1;
            out_exccode  = new_exccode;
            out_badvaddr = new_badvaddr;
        end
    end
`else
    logic unused_new;
    assign unused_new = ^{new_exc, new_exccode, new_badvaddr, NOEXC};

    // Merge disabled: upstream exception fields are forwarded untouched.
    always_comb begin
        out_exc      = in_exc;
        out_exccode  = in_exccode;
        out_badvaddr = in_badvaddr;
    end
`endif

endmodule

// File: rtl/pipe_skid_stage.sv
// Pipeline stage register with valid/ready handshake and a 2-entry skid
// buffer, so in_ready comes from flops only. M is the head entry driving
// out_*, S catches the entry that arrives while the head is stalled.
// Optional macro: PIPE_SKID_STAGE_EXC_MERGE_EN (exception merge at capture).
//
// state    | meaning
// ---------+-----------------------------------------------
// ST_EMPTY | nothing held, out_valid=0
// ST_ONE   | M holds the head entry
// ST_TWO   | M and S both full, in_ready=0
module pipe_skid_stage
    import pipe_pkg::*;
#(
    parameter int DATA_W     = 64,
    parameter int CODE_W     = 5,
    parameter int NOEXC_CODE = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_exc,
    input  logic [CODE_W-1:0] in_exccode,
    input  logic [31:0]       in_badvaddr,
    input  logic              new_exc,
    input  logic [CODE_W-1:0] new_exccode,
    input  logic [31:0]       new_badvaddr,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_exc,
    output logic [CODE_W-1:0] out_exccode,
    output logic [31:0]       out_badvaddr,
    output logic [1:0]        occupancy
);

    localparam logic [CODE_W-1:0] NOEXC = CODE_W'(NOEXC_CODE);

    skid_state_e state, state_nxt;
    logic accept, pop;
    logic ld_m_in, ld_m_s, ld_s_in;

    logic              cap_exc;
    logic [CODE_W-1:0] cap_exccode;
    logic [31:0]       cap_badvaddr;

    logic [DATA_W-1:0] m_data,     s_data;
    logic              m_exc,      s_exc;
    logic [CODE_W-1:0] m_exccode,  s_exccode;
    logic [31:0]       m_badvaddr, s_badvaddr;

    pipe_exc_merge #(
        .CODE_W     (CODE_W),
        .NOEXC_CODE (NOEXC_CODE)
    ) u_exc_merge (
        .in_exc       (in_exc),
        .in_exccode   (in_exccode),
        .in_badvaddr  (in_badvaddr),
        .new_exc      (new_exc),
        .new_exccode  (new_exccode),
        .new_badvaddr (new_badvaddr),
        .out_exc      (cap_exc),
        .out_exccode  (cap_exccode),
        .out_badvaddr (cap_badvaddr)
    );

    assign in_ready  = (state != ST_TWO);
    assign out_valid = (state != ST_EMPTY);
    assign accept    = in_valid & in_ready & ~flush;
    assign pop       = out_valid & out_ready;

    // Next state and which register loads from where.
    always_comb begin
        state_nxt = state;
        ld_m_in   = 1'b0;
        ld_m_s    = 1'b0;
        ld_s_in   = 1'b0;
        occupancy = 2'd0;
        case (state)
            ST_EMPTY: begin
                occupancy = 2'd0;
                if (accept) begin
                    state_nxt = ST_ONE;
                    ld_m_in   = 1'b1;
                end
            end
            ST_ONE: begin
                occupancy = 2'd1;
                if (accept && pop) begin
                    ld_m_in = 1'b1;
                end else if (accept) begin
                    state_nxt = ST_TWO;
                    ld_s_in   = 1'b1;
                end else if (pop) begin
                    state_nxt = ST_EMPTY;
                end
            end
            ST_TWO: begin
                occupancy = 2'd2;
                if (pop) begin
                    state_nxt = ST_ONE;
                    ld_m_s    = 1'b1;
                end
            end
            default: state_nxt = ST_EMPTY;
        endcase
    end

    // State register; flush empties the stage just like reset.
    always_ff @(posedge clk) begin
        if (!rst || flush) begin
            state <= ST_EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    // Entry registers; cleared on reset/flush so a dead stage shows no exception.
    always_ff @(posedge clk) begin
        if (!rst || flush) begin
            m_data     <= '0;
            m_exc      <= 1'b0;
            m_exccode  <= NOEXC;
            m_badvaddr <= '0;
            s_data     <= '0;
            s_exc      <= 1'b0;
            s_exccode  <= NOEXC;
            s_badvaddr <= '0;
        end else begin
            if (ld_m_in) begin
                m_data     <= in_data;
                m_exc      <= cap_exc;
                m_exccode  <= cap_exccode;
                m_badvaddr <= cap_badvaddr;
            end else if (ld_m_s) begin
                m_data     <= s_data;
                m_exc      <= s_exc;
                m_exccode  <= s_exccode;
                m_badvaddr <= s_badvaddr;
            end
            if (ld_s_in) begin
                s_data     <= in_data;
                s_exc      <= cap_exc;
                s_exccode  <= cap_exccode;
                s_badvaddr <= cap_badvaddr;
            end
        end
    end

    assign out_data     = m_data;
    assign out_exc      = m_exc;
    assign out_exccode  = m_exccode;
    assign out_badvaddr = m_badvaddr;

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Directed plus short random bench for pipe_skid_stage with a FIFO scoreboard.
module tb_pipe_skid_stage;
    import pipe_pkg::*;

    localparam int DATA_W = 64;
    localparam int CODE_W = 5;

    logic              clk = 1'b0;
    logic              rst;
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              in_exc;
    logic [CODE_W-1:0] in_exccode;
    logic [31:0]       in_badvaddr;
    logic              new_exc;
    logic [CODE_W-1:0] new_exccode;
    logic [31:0]       new_badvaddr;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic              out_exc;
    logic [CODE_W-1:0] out_exccode;
    logic [31:0]       out_badvaddr;
    logic [1:0]        occupancy;

    typedef struct {
        logic [DATA_W-1:0] d;
        logic              e;
        logic [CODE_W-1:0] c;
        logic [31:0]       b;
    } ent_t;

    ent_t sb[$];
    int checks = 0;
    int failures = 0;

    pipe_skid_stage #(.DATA_W(DATA_W), .CODE_W(CODE_W), .NOEXC_CODE(NOEXC_CODE)) dut (
        .clk          (clk),
        .rst          (rst),
        .flush        (flush),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .in_exc       (in_exc),
        .in_exccode   (in_exccode),
        .in_badvaddr  (in_badvaddr),
        .new_exc      (new_exc),
        .new_exccode  (new_exccode),
        .new_badvaddr (new_badvaddr),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_exc      (out_exc),
        .out_exccode  (out_exccode),
        .out_badvaddr (out_badvaddr),
        .occupancy    (occupancy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
            $error("%s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic ent_t model_capture();
        ent_t r;
        r.d = in_data;
`ifdef PIPE_SKID_STAGE_EXC_MERGE_EN
        if (in_exc) begin
            r.e = 1'b1; r.c = in_exccode; r.b = in_badvaddr;
        end else if (new_exc) begin
            r.e = 1'b1; r.c = new_exccode; r.b = new_badvaddr;
        end else begin
            r.e = 1'b0; r.c = CODE_W'(NOEXC_CODE); r.b = in_badvaddr;
        end
`else
        r.e = in_exc; r.c = in_exccode; r.b = in_badvaddr;
`endif
        return r;
    endfunction

    task automatic set_in(input logic v, input logic [63:0] d,
                          input logic ie, input logic [4:0] ic, input logic [31:0] ib,
                          input logic ne, input logic [4:0] nc, input logic [31:0] nb);
        in_valid = v; in_data = d;
        in_exc = ie; in_exccode = ic; in_badvaddr = ib;
        new_exc = ne; new_exccode = nc; new_badvaddr = nb;
    endtask

    // One clock: score the pop and the capture happening at this edge,
    // then check the handshake outputs against the scoreboard depth.
    task automatic tick();
        bit   acc, pp;
        ent_t exp_e, cap;
        acc = in_valid && in_ready && !flush && rst;
        pp  = out_valid && out_ready && rst;
        cap = model_capture();
        if (pp) begin
            if (sb.size() == 0) begin
                chk("pop_unexpected", 64'd1, 64'd0);
            end else begin
                exp_e = sb.pop_front();
                chk("pop_data", out_data, exp_e.d);
                chk("pop_exc", {63'd0, out_exc}, {63'd0, exp_e.e});
                chk("pop_exccode", {59'd0, out_exccode}, {59'd0, exp_e.c});
                chk("pop_badvaddr", {32'd0, out_badvaddr}, {32'd0, exp_e.b});
            end
        end
        @(posedge clk);
        #1;
        if (!rst || flush) sb.delete();
        else if (acc) sb.push_back(cap);
        chk("occupancy", {62'd0, occupancy}, 64'(sb.size()));
        chk("out_valid", {63'd0, out_valid}, {63'd0, sb.size() != 0});
        chk("in_ready", {63'd0, in_ready}, {63'd0, sb.size() < 2});
        @(negedge clk);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_out_valid"}, {63'd0, out_valid}, 64'd0);
        chk({tag, "_in_ready"}, {63'd0, in_ready}, 64'd1);
        chk({tag, "_occupancy"}, {62'd0, occupancy}, 64'd0);
        chk({tag, "_out_data"}, out_data, 64'd0);
        chk({tag, "_out_exc"}, {63'd0, out_exc}, 64'd0);
        chk({tag, "_out_exccode"}, {59'd0, out_exccode}, 64'(NOEXC_CODE));
        chk({tag, "_out_badvaddr"}, {32'd0, out_badvaddr}, 64'd0);
    endtask

    initial begin
        rst = 1'b0; flush = 1'b0; out_ready = 1'b0;
        set_in(0, 0, 0, 5'd0, 0, 0, 5'd0, 0);
        @(negedge clk);
        tick();
        tick();
        chk_reset_vals("reset");
        rst = 1'b1;

        // Single entry, 1-cycle latency.
        out_ready = 1'b1;
        set_in(1, 64'hA5, 0, 5'd0, 0, 0, 5'd0, 0);
        tick();
        chk("a5_out_valid", {63'd0, out_valid}, 64'd1);
        chk("a5_out_data", out_data, 64'hA5);
        chk("a5_occupancy", {62'd0, occupancy}, 64'd1);
        set_in(0, 0, 0, 5'd0, 0, 0, 5'd0, 0);
        tick();

        // Fill the skid buffer; a third entry must wait.
        out_ready = 1'b0;
        set_in(1, 64'h1, 0, 5'd0, 0, 0, 5'd0, 0);
        tick();
        set_in(1, 64'h2, 0, 5'd0, 0, 0, 5'd0, 0);
        tick();
        set_in(1, 64'h3, 0, 5'd0, 0, 0, 5'd0, 0);
        for (int i = 0; i < 3; i++) tick();
        chk("full_in_ready", {63'd0, in_ready}, 64'd0);
        chk("full_occupancy", {62'd0, occupancy}, 64'd2);
        chk("full_head", out_data, 64'h1);
        out_ready = 1'b1;
        tick();
        tick();
        set_in(0, 0, 0, 5'd0, 0, 0, 5'd0, 0);
        chk("drain_head3", out_data, 64'h3);
        tick();

        // Exception merge.
        out_ready = 1'b0;
        set_in(1, 64'h77, 0, 5'd0, 32'h1234, 1, 5'(EXC_OV), 32'hBFC00010);
        tick();
`ifdef PIPE_SKID_STAGE_EXC_MERGE_EN
        chk("newexc_exc", {63'd0, out_exc}, 64'd1);
        chk("newexc_code", {59'd0, out_exccode}, 64'(EXC_OV));
        chk("newexc_bva", {32'd0, out_badvaddr}, 64'hBFC00010);
`else
        chk("newexc_ignored_exc", {63'd0, out_exc}, 64'd0);
        chk("newexc_ignored_bva", {32'd0, out_badvaddr}, 64'h1234);
`endif
        out_ready = 1'b1;
        set_in(1, 64'h78, 1, 5'(EXC_ADEL), 32'h8000_0004, 1, 5'(EXC_OV), 32'hBFC00010);
        tick();
        chk("inexc_exc", {63'd0, out_exc}, 64'd1);
        chk("inexc_code", {59'd0, out_exccode}, 64'(EXC_ADEL));
        chk("inexc_bva", {32'd0, out_badvaddr}, 64'h8000_0004);
        set_in(0, 0, 0, 5'd0, 0, 0, 5'd0, 0);
        tick();

        // Flush with two held entries and a live input.
        out_ready = 1'b0;
        set_in(1, 64'h11, 1, 5'(EXC_BP), 32'hDEAD, 0, 5'd0, 0);
        tick();
        set_in(1, 64'h22, 1, 5'(EXC_SYS), 32'hBEEF, 0, 5'd0, 0);
        tick();
        flush = 1'b1;
        set_in(1, 64'h33, 1, 5'(EXC_RI), 32'hCAFE, 0, 5'd0, 0);
        tick();
        flush = 1'b0;
        set_in(0, 0, 0, 5'd0, 0, 0, 5'd0, 0);
        chk_reset_vals("flush");

        // Flush coinciding with a pop: the transfer completes, then empty.
        set_in(1, 64'h44, 0, 5'd0, 32'h40, 0, 5'd0, 0);
        tick();
        out_ready = 1'b1;
        flush = 1'b1;
        set_in(1, 64'h45, 0, 5'd0, 0, 0, 5'd0, 0);
        tick();
        flush = 1'b0;
        chk_reset_vals("flush_pop");

        // Reset mid-stall.
        out_ready = 1'b0;
        set_in(1, 64'h55, 1, 5'(EXC_ADES), 32'h55, 0, 5'd0, 0);
        tick();
        set_in(1, 64'h66, 0, 5'd0, 32'h66, 1, 5'(EXC_INT), 32'h99);
        tick();
        chk("prereset_occupancy", {62'd0, occupancy}, 64'd2);
        rst = 1'b0;
        tick();
        rst = 1'b1;
        set_in(0, 0, 0, 5'd0, 0, 0, 5'd0, 0);
        chk_reset_vals("midstall_reset");

        // Random traffic against the scoreboard.
        for (int i = 0; i < 300; i++) begin
            set_in(1'($urandom_range(0, 1)), {$urandom(), $urandom()},
                   1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom(),
                   1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom());
            out_ready = 1'($urandom_range(0, 2) != 0);
            flush = ($urandom_range(0, 19) == 0);
            tick();
        end
        flush = 1'b0;
        set_in(0, 0, 0, 5'd0, 0, 0, 5'd0, 0);
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        chk("final_drained", 64'(sb.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pipe_skid_stage.md
# pipe_skid_stage

Parametrised pipeline stage register with a valid/ready handshake, a 2-entry skid buffer, synchronous flush and first-exception-wins merging of exception status. It replaces fixed-function stage registers between any two core pipeline stages (IF/ID, ID/EX, EX/MEM, MEM/WB). It lets each stage stall independently without a combinational ready path crossing the stage.

## Interface
- DATA_W, 64, width of opaque payload (control + datapath fields concatenated by the instantiating stage)
- CODE_W, 5, exception code width
- NOEXC_CODE, 15, exccode value carried when no exception is pending
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-low; clock clk
- flush  in  1  kill all held entries and any input this cycle
- in_valid  in  1  upstream entry present
- in_ready  out  1  stage can accept; driven from registers only
- in_data  in  DATA_W  upstream payload
- in_exc, in_exccode, in_badvaddr  in  1/CODE_W/32  exception already raised upstream
- new_exc, new_exccode, new_badvaddr  in  1/CODE_W/32  exception detected in the current stage
- out_valid  out  1  entry available downstream
- out_ready  in  1  downstream accepts
- out_data, out_exc, out_exccode, out_badvaddr  out  DATA_W/1/CODE_W/32  head entry
- occupancy  out  2  number of held entries, 0..2

## Operation
- Two entries: M (head, drives out_*) and S (skid). State is EMPTY, ONE or TWO; occupancy is 0, 1 or 2 respectively.
- accept = in_valid & in_ready & !flush. pop = out_valid & out_ready.
- EMPTY: accept -> ONE, M <= input.
- ONE: accept & pop -> ONE, M <= input. accept & !pop -> TWO, S <= input. !accept & pop -> EMPTY. Otherwise hold.
- TWO: in_ready=0. pop -> ONE, M <= S. Otherwise hold.
- in_ready = (state != TWO). out_valid = (state != EMPTY).
- Exception merge applied at capture:
  - in_exc=1: keep the in_* fields.
  - else new_exc=1: exc=1, take the new_* fields.
  - else exc=0, exccode=NOEXC_CODE, badvaddr=in_badvaddr.
- flush: synchronous, priority below reset and above everything else.
  - Goes to EMPTY.
  - M and S payload zeroed; exc=0; exccode=NOEXC_CODE; badvaddr=0.
  - The input presented in the flush cycle is dropped.
- Payload is never inspected or modified.

## Timing
- Reset (rst=0 at edge) and flush produce the same state:
  - out_valid=0, in_ready=1, occupancy=0.
  - out_data=0, out_exc=0, out_exccode=NOEXC_CODE, out_badvaddr=0.
- Latency: an entry accepted into EMPTY appears on out_* at the next edge (1 cycle).
- Throughput: 1 entry/cycle sustained while out_ready=1.
- in_ready falls in the cycle after the second entry is captured. An entry offered while in_ready=0 is not taken; upstream must hold it.
- Order is strictly FIFO. No entry is duplicated or lost except on flush/reset.
- flush together with pop: the downstream transfer still completes that cycle, then the stage is empty.
- Reset asserted mid-stall discards both entries.

## Configuration
- PIPE_SKID_STAGE_EXC_MERGE_EN defined:
  - Merge logic as above.
  - new_* fields are used.
- Not defined:
  - out_exc/out_exccode/out_badvaddr carry in_* unchanged.
  - new_* ports remain present but are ignored (no logic).
  - Flush and reset still load NOEXC_CODE.

## Structure
- Package pipe_pkg holds:
  - NOEXC_CODE.
  - Exception code constants EXC_INT=0, EXC_ADEL=4, EXC_ADES=5, EXC_SYS=8, EXC_BP=9, EXC_RI=10, EXC_OV=12.
  - A typedef for the exception triple {exc, exccode, badvaddr}.
- One sub-module, pipe_exc_merge: combinational priority selection of in_* vs new_*. It is instantiated once, at the capture input.

## Test plan
- Reset, then in_valid=1, data=0xA5, out_ready=1 -> out_valid=1 with out_data=0xA5 one cycle later; occupancy=1.
- out_ready=0, push 0x1 then 0x2 -> occupancy=2, in_ready=0. A third push of 0x3 held 3 cycles is not taken. Raise out_ready -> 0x1, 0x2, 0x3 emerge in order, back-to-back.
- in_exc=0, new_exc=1, new_exccode=12 (EXC_OV), new_badvaddr=0xBFC00010 -> out_exc=1, code 12, badvaddr 0xBFC00010. Repeat with in_exc=1, code 4 -> code 4 retained.
- Two entries held, flush=1 with in_valid=1 -> next cycle occupancy=0, out_valid=0, out_exccode=15, input not captured.
- rst=0 while occupancy=2 -> all outputs at reset values next cycle. Build without PIPE_SKID_STAGE_EXC_MERGE_EN and new_exc=1 -> out_exc follows in_exc=0.
